// File: rtl/fb_scanout_pkg.sv
// fb_scanout_pkg: scanout FSM states, display geometry and address-window preamble bytes
package fb_scanout_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_FETCH, S_LATCH, S_SHIFT, S_NEXT, S_DONE} state_t;
  localparam int NUM_COLS = 128;
  localparam int NUM_PAGES = 8;
  localparam int PRE_LEN = 6;
  function automatic logic [7:0] preamble_byte(input logic [2:0] k);
    return k == 3'd0 ? 8'h21 : k == 3'd1 ? 8'h00 : k == 3'd2 ? 8'h7F :
           k == 3'd3 ? 8'h22 : k == 3'd4 ? 8'h00 : 8'h07;
  endfunction
endpackage

// File: rtl/fb_scanout_spi_byte_tx.sv
// fb_scanout_spi_byte_tx: SPI mode-0 MSB-first byte shifter, SCK half-period clkDiv_p, done in last cycle
module fb_scanout_spi_byte_tx #(
  parameter int unsigned clkDiv_p = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic [7:0] byte_i,
  output logic       sck_o,
  output logic       mosi_o,
  output logic       done_o
);
  localparam logic [7:0] DIV_LAST = 8'(clkDiv_p - 1);
  logic [6:0] sh_q, sh_d;
  logic [7:0] div_q, div_d;
  logic [2:0] bit_q, bit_d;
  logic act_q, act_d, sck_q, sck_d, mosi_q, mosi_d, tick, fall;
  always_comb begin
    tick = act_q && div_q == DIV_LAST;
    fall = tick && sck_q;
    done_o = fall && bit_q == 3'd7;
    sh_d = load_i ? byte_i[6:0] : fall ? {sh_q[5:0], 1'b0} : sh_q;
    mosi_d = load_i ? byte_i[7] : fall ? sh_q[6] : mosi_q;
    sck_d = load_i ? 1'b0 : tick ? !sck_q : sck_q;
    div_d = (load_i || tick) ? 8'd0 : act_q ? div_q + 8'd1 : div_q;
    bit_d = load_i ? 3'd0 : fall ? bit_q + 3'd1 : bit_q;
    act_d = load_i || (act_q && !done_o);
  end
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      sh_q <= '0;
      div_q <= '0;
      bit_q <= '0;
      act_q <= 1'b0;
      sck_q <= 1'b0;
      mosi_q <= 1'b0;
    end else begin
      sh_q <= sh_d;
      div_q <= div_d;
      bit_q <= bit_d;
      act_q <= act_d;
      sck_q <= sck_d;
      mosi_q <= mosi_d;
    end
  end
  assign sck_o = sck_q;
  assign mosi_o = mosi_q;
endmodule

// File: rtl/fb_scanout.sv
// fb_scanout: streams the 128x64 framebuffer to an SSD1306 over SPI; FB_SCANOUT_PREAMBLE_EN adds the address-window preamble
module fb_scanout
  import fb_scanout_pkg::*;
#(
  parameter int unsigned clkDiv_p = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  output logic        fb_ext_o,
  output logic [8:0]  fb_raddr_o,
  input  logic [15:0] fb_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        sck_o,
  output logic        mosi_o,
  output logic        dc_o,
  output logic        cs_o
);
`ifdef FB_SCANOUT_PREAMBLE_EN
  localparam state_t FIRST = S_CMD;
  localparam logic DC_FIRST = 1'b0;
`else
  localparam state_t FIRST = S_FETCH;
  localparam logic DC_FIRST = 1'b1;
`endif
  localparam logic [6:0] C_LAST = 7'(NUM_COLS - 1);
  localparam logic [2:0] P_LAST = 3'(NUM_PAGES - 1);
  localparam logic [2:0] K_LAST = 3'(PRE_LEN - 1);
  state_t state_q, state_d;
  logic [6:0] c_q, c_d;
  logic [2:0] p_q, p_d, k_q, k_d;
  logic dc_q, dc_d, busy_q, busy_d, cs_q, cs_d, done_q, done_d;
  logic load, tx_done;
  logic [7:0] tx_byte;
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
      c_q <= '0;
      p_q <= '0;
      k_q <= '0;
      dc_q <= 1'b0;
      busy_q <= 1'b0;
      cs_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q <= c_d;
      p_q <= p_d;
      k_q <= k_d;
      dc_q <= dc_d;
      busy_q <= busy_d;
      cs_q <= cs_d;
      done_q <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    c_d = c_q;
    p_d = p_q;
    k_d = k_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        state_d = FIRST;
        c_d = '0;
        p_d = '0;
        k_d = '0;
      end
      S_CMD: state_d = S_SHIFT;
      S_FETCH: state_d = S_LATCH;
      S_LATCH: state_d = S_SHIFT;
      S_SHIFT: state_d = tx_done ? S_NEXT : S_SHIFT;
      S_NEXT: if (!dc_q) begin
        k_d = k_q + 3'd1;
        state_d = k_q == K_LAST ? S_FETCH : S_CMD;
      end else begin
        c_d = c_q + 7'd1;
        p_d = c_q == C_LAST ? p_q + 3'd1 : p_q;
        state_d = (c_q == C_LAST && p_q == P_LAST) ? S_DONE : S_FETCH;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    load = state_q == S_CMD || state_q == S_LATCH;
    tx_byte = state_q == S_CMD ? preamble_byte(k_q) : p_q[0] ? fb_data_i[15:8] : fb_data_i[7:0];
    busy_d = state_d != S_IDLE && state_d != S_DONE;
    cs_d = !busy_d;
    done_d = state_d == S_DONE;
    dc_d = state_d == S_DONE ? 1'b0 : state_q == S_LATCH ? 1'b1 : state_q == S_CMD ? 1'b0 :
           (state_q == S_IDLE && start_i) ? DC_FIRST : dc_q;
  end
  fb_scanout_spi_byte_tx #(.clkDiv_p(clkDiv_p)) u_tx (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .load_i(load),
    .byte_i(tx_byte),
    .sck_o(sck_o),
    .mosi_o(mosi_o),
    .done_o(tx_done)
  );
  assign fb_raddr_o = {p_q[2:1], c_q};
  assign fb_ext_o = busy_q;
  assign busy_o = busy_q;
  assign cs_o = cs_q;
  assign done_o = done_q;
  assign dc_o = dc_q;
endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: directed checks of fb_scanout byte stream, timing, reset and SCK divider
module tb_fb_scanout;
`ifdef FB_SCANOUT_PREAMBLE_EN
  localparam int NPRE = 6;
  localparam logic DC0 = 1'b0;
`else
  localparam int NPRE = 0;
  localparam logic DC0 = 1'b1;
`endif
  localparam int FRAME = NPRE * 34 + 1024 * 35;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_i, start, start1;
  logic fb_ext, busy, done, sck, mosi, dc, cs;
  logic fb_ext1, busy1, done1, sck1, mosi1, dc1, cs1;
  logic [8:0] raddr, raddr1;
  logic [15:0] fb_data, fb_data1;
  logic [15:0] mem [0:511];
  fb_scanout #(.clkDiv_p(2)) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start), .fb_ext_o(fb_ext), .fb_raddr_o(raddr),
    .fb_data_i(fb_data), .busy_o(busy), .done_o(done), .sck_o(sck), .mosi_o(mosi), .dc_o(dc), .cs_o(cs)
  );
  fb_scanout #(.clkDiv_p(1)) dut1 (
    .clk_i(clk), .reset_i(reset_i), .start_i(start1), .fb_ext_o(fb_ext1), .fb_raddr_o(raddr1),
    .fb_data_i(fb_data1), .busy_o(busy1), .done_o(done1), .sck_o(sck1), .mosi_o(mosi1), .dc_o(dc1), .cs_o(cs1)
  );
  always @(posedge clk) begin
    fb_data <= mem[raddr];
    fb_data1 <= mem[raddr1];
  end
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic sck_p = 1'b0, mosi_p = 1'b0;
  logic [6:0] sh = '0;
  int bitc = 0, nb = 0, nrise = 0, viol = 0;
  logic [7:0] rx [0:2047];
  logic rx_dc [0:2047];
  wire rise = sck & ~sck_p;
  always @(posedge clk) begin
    sck_p <= sck;
    mosi_p <= mosi;
    nrise <= nrise + int'(rise);
    if (sck && mosi != mosi_p) viol <= viol + 1;
    if (cs) bitc <= 0;
    else if (rise) begin
      sh <= {sh[5:0], mosi};
      if (bitc == 7) begin
        if (nb < 2048) begin
          rx[nb] <= {sh, mosi};
          rx_dc[nb] <= dc;
        end
        nb <= nb + 1;
        bitc <= 0;
      end else bitc <= bitc + 1;
    end
  end
  logic sck1_p = 1'b0, mosi1_p = 1'b0;
  logic [6:0] sh1 = '0;
  int bitc1 = 0, nb1 = 0, viol1 = 0, last1 = 0, per1 = 0;
  logic [7:0] rx1 [0:31];
  wire rise1 = sck1 & ~sck1_p;
  always @(posedge clk) begin
    sck1_p <= sck1;
    mosi1_p <= mosi1;
    if (sck1 && mosi1 != mosi1_p) viol1 <= viol1 + 1;
    if (rise1) begin
      per1 <= cyc - last1;
      last1 <= cyc;
    end
    if (cs1) bitc1 <= 0;
    else if (rise1) begin
      sh1 <= {sh1[5:0], mosi1};
      if (bitc1 == 7) begin
        if (nb1 < 32) rx1[nb1] <= {sh1, mosi1};
        nb1 <= nb1 + 1;
        bitc1 <= 0;
      end else bitc1 <= bitc1 + 1;
    end
  end
  logic busy_p = 1'b0;
  int t_start = 0, t_done = 0, ndone = 0;
  always @(negedge clk) begin
    busy_p <= busy;
    if (busy && !busy_p) t_start <= cyc;
    if (done) begin
      t_done <= cyc;
      ndone <= ndone + 1;
    end
  end
  int passed = 0, fails = 0, total = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  int dn [10] = '{0, 1, 127, 128, 259, 387, 517, 522, 645, 1023};
  logic [7:0] dv [10] = '{8'h33, 8'h32, 8'h4C, 8'h5C, 8'hB0, 8'h1D, 8'h5A, 8'hB9, 8'hA5, 8'hA3};
  logic [7:0] pre [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};
  initial begin
    logic [8:0] aa;
    int base, r0;
    for (int a = 0; a < 512; a++) begin
      aa = 9'(a);
      mem[a] = {aa[8:1] ^ 8'h5C, {aa[8] ^ aa[7], aa[6:0]} ^ 8'h33};
    end
    mem[9'h105] = 16'hA55A;
    reset_i = 1'b0;
    start = 1'b0;
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    chk("rst_cs", cs, 1);
    chk("rst_sck", sck, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_dc", dc, 0);
    chk("rst_ext", fb_ext, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_raddr", raddr, 0);
    r0 = nrise;
    repeat (100) @(negedge clk);
    chk("idle_sck_edges", nrise - r0, 0);
    chk("idle_cs", cs, 1);
    chk("idle_ext", fb_ext, 0);
    base = nb;
    pulse_start();
    chk("start_ext", fb_ext, 1);
    chk("start_busy", busy, 1);
    chk("start_cs", cs, 0);
    chk("start_dc", dc, DC0);
    repeat (498) @(negedge clk);
    pulse_start();
    for (int i = 0; i < 40000 && ndone == 0; i++) @(negedge clk);
    chk("frame_done_seen", ndone, 1);
    repeat (200) @(negedge clk);
    chk("one_done", ndone, 1);
    chk("frame_cycles", t_done - t_start, FRAME);
    chk("byte_count", nb - base, NPRE + 1024);
    chk("end_busy", busy, 0);
    chk("end_cs", cs, 1);
    chk("end_ext", fb_ext, 0);
    chk("mosi_stable_div2", viol, 0);
    for (int k = 0; k < NPRE; k++) begin
      chk($sformatf("pre_byte%0d", k), rx[base + k], pre[k]);
      chk($sformatf("pre_dc%0d", k), rx_dc[base + k], 0);
    end
    for (int j = 0; j < 10; j++) begin
      chk($sformatf("data_byte%0d", dn[j]), rx[base + NPRE + dn[j]], dv[j]);
      chk($sformatf("data_dc%0d", dn[j]), rx_dc[base + NPRE + dn[j]], 1);
    end
    base = nb;
    pulse_start();
    for (int i = 0; i < 20000 && nb < base + NPRE + 300; i++) @(negedge clk);
    chk("reach_byte300", nb >= base + NPRE + 300, 1);
    reset_i = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_cs", cs, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_ext", fb_ext, 0);
    chk("midrst_sck", sck, 0);
    chk("midrst_done", done, 0);
    @(negedge clk);
    reset_i = 1'b1;
    repeat (50) @(negedge clk);
    chk("midrst_no_done", ndone, 1);
    base = nb;
    pulse_start();
    for (int i = 0; i < 2000 && nb < base + NPRE + 2; i++) @(negedge clk);
    chk("restart_bytes", nb >= base + NPRE + 2, 1);
    if (NPRE > 0) chk("restart_pre0", rx[base], 8'h21);
    chk("restart_first", rx[base + NPRE], 8'h33);
    chk("restart_second", rx[base + NPRE + 1], 8'h32);
    reset_i = 1'b0;
    repeat (2) @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 2000 && nb1 < NPRE + 2; i++) @(negedge clk);
    chk("div1_bytes", nb1 >= NPRE + 2, 1);
    chk("div1_period", per1, 2);
    chk("div1_mosi_stable", viol1, 0);
    chk("div1_first", rx1[NPRE], 8'h33);
    chk("div1_second", rx1[NPRE + 1], 8'h32);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
